req_demux_4_32: RTL and testbench

//  Request-side counterpart of the 4:1 datapath selectors: takes one CPU load/store request and routes it to one of

---
 rtl/req_demux_4_32_pkg.sv | 29 ++
 rtl/req_demux_4_32_mux.sv | 24 ++
 rtl/req_demux_4_32.sv | 178 +++++++++++++++++
 tb/tb_req_demux_4_32.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_demux_4_32_pkg.sv
// Shared definitions for the request demultiplexer: state encoding,
// target count, select width, response error codes and small helpers.
package req_demux_4_32_pkg;

  localparam int NT        = 4;
  localparam int TGT_SEL_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RSP  = 2'd3;

  // Value driven on rsp_err for a failed (misaligned or timed-out) transaction.
  localparam logic RSP_ERR = 1'b1;
  localparam logic RSP_OK  = 1'b0;

  // A request is misaligned when either of the two low address bits is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

  // One-hot request-valid pattern for the selected target.
  function automatic logic [NT-1:0] tgt_onehot(input logic [TGT_SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/req_demux_4_32_mux.sv
// 4:1 read-data selector: picks one target's read data out of the
// concatenated read-data bus using the latched target index.
module req_demux_4_32_mux
  import req_demux_4_32_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [TGT_SEL_W-1:0] sel,
  input  logic [NT*DW-1:0]     din,
  output logic [DW-1:0]        dout
);

  // Select the DW-wide slice belonging to the addressed target.
  always_comb begin
    case (sel)
      2'd0:    dout = din[0*DW +: DW];
      2'd1:    dout = din[1*DW +: DW];
      2'd2:    dout = din[2*DW +: DW];
      2'd3:    dout = din[3*DW +: DW];
      default: dout = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/req_demux_4_32.sv
// Request demultiplexer: accepts one CPU load/store, forwards it to one of
// four targets chosen by address bits, waits for the accept (and read data
// for loads), then returns a single response pulse. A cycle counter aborts
// transactions to targets that never answer.
module req_demux_4_32
  import req_demux_4_32_pkg::*;
#(
  parameter int DW      = 32,
  parameter int SEL_LO  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic             in_we,
  input  logic [3:0]       in_be,
  input  logic [DW-1:0]    in_wdata,
  output logic [NT-1:0]    out_valid,
  input  logic [NT-1:0]    out_ready,
  output logic [31:0]      out_addr,
  output logic             out_we,
  output logic [3:0]       out_be,
  output logic [DW-1:0]    out_wdata,
  input  logic [NT-1:0]    t_rvalid,
  input  logic [NT*DW-1:0] t_rdata,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [TGT_SEL_W-1:0]   sel_r;
  logic [CW-1:0]          cnt_r;
  logic [31:0]            addr_r;
  logic                   we_r;
  logic [3:0]             be_r;
  logic [DW-1:0]          wdata_r;
  logic [DW-1:0]          rsp_data_r;
  logic                   rsp_err_r;
  logic [DW-1:0]          mux_rdata_s;
  logic                   hs_req_s;
  logic                   hs_rd_s;
  logic                   tmo_s;
  logic                   mis_s;

  req_demux_4_32_mux #(.DW(DW)) u_rdata_mux (
    .sel  (sel_r),
    .din  (t_rdata),
    .dout (mux_rdata_s)
  );

  // Only the selected target's handshakes matter; all others are ignored.
  assign hs_req_s = out_ready[sel_r];
  assign hs_rd_s  = t_rvalid[sel_r];
  assign tmo_s    = (cnt_r == CW'(TIMEOUT - 1));
  assign mis_s    = is_misaligned(in_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a handshake takes priority over a same-cycle timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          next_state_s = mis_s ? ST_RSP : ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (hs_req_s) begin
          next_state_s = we_r ? ST_RSP : ST_WAIT;
        end else if (tmo_s) begin
          next_state_s = ST_RSP;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (hs_rd_s || tmo_s) begin
          next_state_s = ST_RSP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RSP:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = {NT{1'b0}};
    rsp_valid = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_REQ:  out_valid = tgt_onehot(sel_r);
      ST_WAIT: in_ready  = 1'b0;
      ST_RSP:  rsp_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Request latches, timeout counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r      <= {TGT_SEL_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      addr_r     <= 32'h0;
      we_r       <= 1'b0;
      be_r       <= 4'h0;
      wdata_r    <= {DW{1'b0}};
      rsp_data_r <= {DW{1'b0}};
      rsp_err_r  <= RSP_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            addr_r     <= in_addr;
            we_r       <= in_we;
            be_r       <= in_be;
            wdata_r    <= in_wdata;
            sel_r      <= in_addr[SEL_LO+1:SEL_LO];
            cnt_r      <= {CW{1'b0}};
            rsp_data_r <= {DW{1'b0}};
            rsp_err_r  <= mis_s ? RSP_ERR : RSP_OK;
          end
        end
        ST_REQ: begin
          if (hs_req_s) begin
            cnt_r     <= {CW{1'b0}};
            rsp_err_r <= RSP_OK;
          end else if (tmo_s) begin
            rsp_data_r <= {DW{1'b0}};
            rsp_err_r  <= RSP_ERR;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WAIT: begin
          if (hs_rd_s) begin
            rsp_data_r <= mux_rdata_s;
            rsp_err_r  <= RSP_OK;
          end else if (tmo_s) begin
            rsp_data_r <= {DW{1'b0}};
            rsp_err_r  <= RSP_ERR;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RSP:  cnt_r <= {CW{1'b0}};
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  assign out_addr  = addr_r;
  assign out_we    = we_r;
  assign out_be    = be_r;
  assign out_wdata = wdata_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_req_demux_4_32.sv
// Self-checking bench for req_demux_4_32. Each transaction is described by
// the target behaviour (cycle of accept, cycle of read data); the expected
// waveform is computed from those numbers and checked every cycle.
module tb_req_demux_4_32;

  localparam int DW = 32;
  localparam int T  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_addr;
  logic           in_we;
  logic [3:0]     in_be;
  logic [DW-1:0]  in_wdata;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [31:0]    out_addr;
  logic           out_we;
  logic [3:0]     out_be;
  logic [DW-1:0]  out_wdata;
  logic [3:0]     t_rvalid;
  logic [4*DW-1:0] t_rdata;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;

  always #5 clk = ~clk;

  req_demux_4_32 #(.DW(DW), .SEL_LO(8), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_we(in_we),
    .in_be(in_be), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_we(out_we),
    .out_be(out_be), .out_wdata(out_wdata),
    .t_rvalid(t_rvalid), .t_rdata(t_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Current transaction: r = REQ cycle (0-based) in which the target accepts,
  // v = WAIT cycle (0-based) in which read data arrives.
  logic        t_mis, t_we;
  int          t_sel, t_r, t_v;
  logic [31:0] t_addr, t_wdata, t_rd;
  logic [3:0]  t_be;
  logic        active = 1'b0;
  logic        cmp_en = 1'b0;
  logic        stray_all = 1'b0;
  int          cur_j = 0;

  // Observations recorded per transaction for literal checks.
  int          ov_cycles, rsp_j_seen;
  logic [3:0]  ov_val;
  logic [31:0] wd_seen, rd_seen;
  logic        err_seen;

  function automatic int nreq();
    return (t_r <= T - 1) ? t_r + 1 : T;
  endfunction

  function automatic logic exp_err();
    return t_mis || (t_r > T - 1) || (!t_we && t_v > T - 1);
  endfunction

  function automatic int resp_j();
    if (t_mis) return 1;
    if (t_r > T - 1 || t_we) return nreq() + 1;
    if (t_v <= T - 1) return t_r + t_v + 3;
    return nreq() + 1 + T;
  endfunction

  function automatic logic [31:0] exp_data();
    return (!exp_err() && !t_we) ? t_rd : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction-level expectation.
  always @(negedge clk) begin
    logic [3:0] e_ov;
    logic       e_rv, e_ir;
    if (cmp_en) begin
      if (active) begin
        e_ov = (!t_mis && cur_j <= nreq()) ? (4'b0001 << t_sel) : 4'b0000;
        e_rv = (cur_j == resp_j());
        e_ir = 1'b0;
      end else begin
        e_ov = 4'b0000;
        e_rv = 1'b0;
        e_ir = 1'b1;
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
      chk("out_valid", {28'b0, out_valid}, {28'b0, e_ov});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
      if (e_rv) begin
        chk("rsp_data", rsp_data, exp_data());
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err()});
      end
      if (e_ov != 4'b0000) begin
        chk("out_addr", out_addr, t_addr);
        chk("out_we", {31'b0, out_we}, {31'b0, t_we});
        chk("out_be", {28'b0, out_be}, {28'b0, t_be});
        chk("out_wdata", out_wdata, t_wdata);
      end
      if (active && out_valid != 4'b0000) begin
        ov_cycles++;
        ov_val  = out_valid;
        wd_seen = out_wdata;
      end
      if (active && rsp_valid) begin
        rsp_j_seen = cur_j;
        rd_seen    = rsp_data;
        err_seen   = rsp_err;
      end
    end
  end

  task automatic drive_targets(input int j);
    logic [3:0]      orr, trv;
    logic [4*DW-1:0] rdv;
    int              nr;
    orr = 4'($urandom);
    trv = 4'($urandom);
    rdv = {$urandom, $urandom, $urandom, $urandom};
    if (stray_all) begin
      orr = 4'b1111;
      trv = 4'b1111;
    end
    if (!t_mis) begin
      nr = nreq();
      if (j <= nr) orr[t_sel] = (j == t_r + 1);
      else         trv[t_sel] = (j == nr + 1 + t_v);
      rdv[t_sel*DW +: DW] = t_rd;
    end
    out_ready = orr;
    t_rvalid  = trv;
    t_rdata   = rdv;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      out_ready = 4'($urandom);
      t_rvalid  = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int r, input int v,
                         input logic [31:0] rd, input int abort_j);
    int rj;
    t_addr = addr; t_we = we; t_be = be; t_wdata = wdata; t_r = r; t_v = v; t_rd = rd;
    t_sel  = int'(addr[9:8]);
    t_mis  = (addr[1:0] != 2'b00);
    rj     = resp_j();
    @(negedge clk);
    in_valid = 1'b1; in_addr = addr; in_we = we; in_be = be; in_wdata = wdata;
    out_ready = 4'($urandom);
    t_rvalid  = 4'($urandom);
    @(posedge clk);
    #1;
    ov_cycles = 0; rsp_j_seen = 0; ov_val = 4'b0; wd_seen = 32'h0; rd_seen = 32'h0; err_seen = 1'b0;
    cur_j  = 1;
    active = 1'b1;
    for (int j = 1; j <= rj; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_addr  = $urandom;
      in_we    = 1'($urandom);
      in_be    = 4'($urandom);
      in_wdata = $urandom;
      drive_targets(j);
      if (j == abort_j) begin
        #2;
        reset  = 1'b0;
        active = 1'b0;
        #1;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        break;
      end
      @(posedge clk);
      #1;
      if (j < rj) cur_j = j + 1;
      else        active = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          pick;
    reset = 1'b0; in_valid = 1'b0; in_addr = 32'h0; in_we = 1'b0; in_be = 4'h0;
    in_wdata = 32'h0; out_ready = 4'h0; t_rvalid = 4'h0; t_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_out_valid", {28'b0, out_valid}, 32'h0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("reset_out_addr", out_addr, 32'h0);
    chk("reset_out_wdata", out_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Aligned write to target 1, accepted immediately.
    run_txn(32'h0000_0104, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    chk("d1_ov_cycles", ov_cycles, 32'd1);
    chk("d1_ov_val", {28'b0, ov_val}, 32'h2);
    chk("d1_wdata", wd_seen, 32'hDEAD_BEEF);
    chk("d1_rsp_cycle", rsp_j_seen, 32'd2);
    chk("d1_err", {31'b0, err_seen}, 32'h0);
    idle(1);

    // Aligned read to target 3 with immediate data.
    run_txn(32'h0000_0300, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1234_5678, 0);
    chk("d2_ov_val", {28'b0, ov_val}, 32'h8);
    chk("d2_rsp_cycle", rsp_j_seen, 32'd3);
    chk("d2_data", rd_seen, 32'h1234_5678);
    chk("d2_err", {31'b0, err_seen}, 32'h0);

    // Misaligned read: no target is addressed.
    run_txn(32'h0000_0002, 1'b0, 4'hF, 32'h0, 0, 0, 32'h5555_AAAA, 0);
    chk("d3_ov_cycles", ov_cycles, 32'd0);
    chk("d3_rsp_cycle", rsp_j_seen, 32'd1);
    chk("d3_err", {31'b0, err_seen}, 32'h1);
    chk("d3_data", rd_seen, 32'h0);

    // Target 2 never accepts: timeout after 16 REQ cycles.
    run_txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1000, 0, 32'h7777_7777, 0);
    chk("d4_ov_cycles", ov_cycles, 32'd16);
    chk("d4_ov_val", {28'b0, ov_val}, 32'h4);
    chk("d4_rsp_cycle", rsp_j_seen, 32'd17);
    chk("d4_err", {31'b0, err_seen}, 32'h1);
    chk("d4_data", rd_seen, 32'h0);
    idle(2);

    // Accept on the timeout cycle, stray handshakes from other targets.
    stray_all = 1'b1;
    run_txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 15, 1, 32'hCAFE_F00D, 0);
    chk("d5_ov_cycles", ov_cycles, 32'd16);
    chk("d5_rsp_cycle", rsp_j_seen, 32'd19);
    chk("d5_data", rd_seen, 32'hCAFE_F00D);
    chk("d5_err", {31'b0, err_seen}, 32'h0);
    run_txn(32'h0000_0204, 1'b1, 4'h3, 32'h0BAD_F00D, 15, 0, 32'h0, 0);
    chk("d6_rsp_cycle", rsp_j_seen, 32'd17);
    chk("d6_err", {31'b0, err_seen}, 32'h0);
    // Read data on the last WAIT cycle, then one cycle too late.
    run_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, 15, 32'h0F0F_0F0F, 0);
    chk("d7_rsp_cycle", rsp_j_seen, 32'd18);
    chk("d7_err", {31'b0, err_seen}, 32'h0);
    run_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, 16, 32'h0F0F_0F0F, 0);
    chk("d8_rsp_cycle", rsp_j_seen, 32'd18);
    chk("d8_err", {31'b0, err_seen}, 32'h1);
    stray_all = 1'b0;

    // Randomized transactions.
    for (int k = 0; k < 60; k++) begin
      int rr, vv;
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else                           a[1:0] = 2'b00;
      pick = $urandom_range(0, 7);
      rr = (pick < 4) ? pick : ((pick == 4) ? 14 : (pick == 5) ? 15 : (pick == 6) ? 16 : 30);
      pick = $urandom_range(0, 7);
      vv = (pick < 4) ? pick : ((pick == 4) ? 14 : (pick == 5) ? 15 : (pick == 6) ? 16 : 30);
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, rr, vv, $urandom, 0);
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of a WAIT: transaction dropped, no response.
    run_txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 0, 1000, 32'h1111_2222, 4);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(20);
    run_txn(32'h0000_0008, 1'b1, 4'h1, 32'hA5A5_5A5A, 1, 0, 32'h0, 0);
    chk("post_rst_rsp_cycle", rsp_j_seen, 32'd3);
    chk("post_rst_err", {31'b0, err_seen}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
